// File: rtl/hdmi_period_scheduler_if.sv
// hdmi_period_scheduler_if: run control, pixel handshake and timing outputs of the HDMI period scheduler.
interface hdmi_period_scheduler_if;
    logic       en_i;
    logic       px_valid_i;
    logic       clr_i;
    logic       px_req_o;
    logic [1:0] period_o;
    logic [3:0] ctl_o;
    logic       h_sync_o;
    logic       v_sync_o;
    logic       frame_start_o;
    logic       busy_o;
    logic       underflow_o;
    modport master (
        output en_i, px_valid_i, clr_i,
        input  px_req_o, period_o, ctl_o, h_sync_o, v_sync_o, frame_start_o, busy_o, underflow_o
    );
    modport slave (
        input  en_i, px_valid_i, clr_i,
        output px_req_o, period_o, ctl_o, h_sync_o, v_sync_o, frame_start_o, busy_o, underflow_o
    );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster counters plus registered per-cycle CTRL/PREAMBLE/GUARD/VIDEO scheduling.
// Starts and stops only on frame boundaries; all outputs lag the counters by one cycle.
module hdmi_period_scheduler #(
    parameter int X_RES  = 1920,
    parameter int Y_RES  = 1080,
    parameter int H_FP   = 88,
    parameter int H_SYNC = 44,
    parameter int H_BP   = 148,
    parameter int V_FP   = 4,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 36,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    hdmi_period_scheduler_if.slave bus
);
    localparam int H_TOTAL = X_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = Y_RES + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STOP_PEND = 2'd2;
    localparam logic [1:0] P_CTRL = 2'd0, P_PRE = 2'd1, P_GUARD = 2'd2, P_VIDEO = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    period_q, period_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          px_req_q, px_req_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          frame_start_q, frame_start_d;
    logic          busy_q, busy_d;
    logic          underflow_q, underflow_d;
    logic          run, h_last, v_last, active, next_active, hs_act, vs_act;

    always_comb begin
        run         = state_q != IDLE;
        h_last      = h_q == HW'(H_TOTAL - 1);
        v_last      = v_q == VW'(V_TOTAL - 1);
        active      = h_q < HW'(X_RES) && v_q < VW'(Y_RES);
        // Preamble/guard lead into the next line, so they depend on whether that line is active.
        next_active = v_q < VW'(Y_RES - 1) || v_last;
        hs_act      = h_q >= HW'(X_RES + H_FP) && h_q <= HW'(X_RES + H_FP + H_SYNC - 1);
        vs_act      = v_q >= VW'(Y_RES + V_FP) && v_q <= VW'(Y_RES + V_FP + V_SYNC - 1);
        h_d         = !run || h_last ? '0 : h_q + HW'(1);
        v_d         = !run ? '0 : h_last ? (v_last ? '0 : v_q + VW'(1)) : v_q;
        state_d     = state_q == IDLE ? (bus.en_i ? RUN : IDLE) :
                      bus.en_i ? RUN :
                      state_q == STOP_PEND && h_last && v_last ? IDLE : STOP_PEND;
        period_d    = !run ? P_CTRL :
                      active ? P_VIDEO :
                      next_active && h_q >= HW'(H_TOTAL - 10) && h_q <= HW'(H_TOTAL - 3) ? P_PRE :
                      next_active && h_q >= HW'(H_TOTAL - 2) ? P_GUARD : P_CTRL;
        px_req_d      = period_d == P_VIDEO;
        ctl_d         = {3'b000, period_d == P_PRE};
        h_sync_d      = run && hs_act ? HS_POL : !HS_POL;
        v_sync_d      = run && vs_act ? VS_POL : !VS_POL;
        frame_start_d = run && h_q == '0 && v_q == '0;
        busy_d        = run;
        // A fresh underflow outranks a simultaneous clear.
        underflow_d   = (px_req_q && !bus.px_valid_i) || (underflow_q && !bus.clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            period_q      <= P_CTRL;
            ctl_q         <= '0;
            px_req_q      <= 1'b0;
            h_sync_q      <= !HS_POL;
            v_sync_q      <= !VS_POL;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            period_q      <= period_d;
            ctl_q         <= ctl_d;
            px_req_q      <= px_req_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            underflow_q   <= underflow_d;
        end
    end

    assign bus.px_req_o      = px_req_q;
    assign bus.period_o      = period_q;
    assign bus.ctl_o         = ctl_q;
    assign bus.h_sync_o      = h_sync_q;
    assign bus.v_sync_o      = v_sync_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.busy_o        = busy_q;
    assign bus.underflow_o   = underflow_q;
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: frame-position reference model with random stimulus, a coordinate table
// for one captured frame, and directed underflow / stop / restart / async-reset sequences.
module tb_hdmi_period_scheduler;
    localparam int XR = 16, YR = 4, HFP = 2, HSW = 3, HBP = 12, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = XR + HFP + HSW + HBP;
    localparam int VT = YR + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam bit HSP = 1'b1, VSP = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hdmi_period_scheduler_if bus();

    hdmi_period_scheduler #(
        .X_RES(XR), .Y_RES(YR), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        logic [1:0] per;
        logic [3:0] ctl;
        logic hs;
        logic vs;
        logic fs;
    } vec_t;

    vec_t tbl[$];
    int checks = 0, errors = 0;
    bit m_run, m_stop;
    int m_pos;
    logic [10:0] exp_o;
    logic exp_uf;
    logic [10:0] cap [FRAME];

    // {px_req, period, ctl, h_sync, v_sync, frame_start, busy}
    function automatic logic [10:0] expect_out(input bit run, input int pos);
        int h, v;
        bit nxt;
        logic [1:0] per;
        logic hs, vs;
        if (!run) return {1'b0, 2'd0, 4'd0, !HSP, !VSP, 1'b0, 1'b0};
        h   = pos % HT;
        v   = pos / HT;
        nxt = ((v + 1) % VT) < YR;
        per = (h < XR && v < YR) ? 2'd3 :
              (nxt && h >= HT - 10 && h <= HT - 3) ? 2'd1 :
              (nxt && h >= HT - 2) ? 2'd2 : 2'd0;
        hs  = (h >= XR + HFP && h < XR + HFP + HSW) ? HSP : !HSP;
        vs  = (v >= YR + VFP && v < YR + VFP + VSW) ? VSP : !VSP;
        return {per == 2'd3, per, (per == 2'd1) ? 4'b0001 : 4'b0000, hs, vs, pos == 0, 1'b1};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.px_req_o, bus.period_o, bus.ctl_o, bus.h_sync_o, bus.v_sync_o, bus.frame_start_o, bus.busy_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic uf_n;
        @(posedge clk);
        #1;
        if (rst) begin
            m_run = 0; m_stop = 0; m_pos = 0;
            exp_o = expect_out(0, 0); exp_uf = 1'b0;
        end else begin
            uf_n   = (exp_o[10] && !bus.px_valid_i) || (exp_uf && !bus.clr_i);
            exp_o  = expect_out(m_run, m_pos);
            exp_uf = uf_n;
            if (!m_run) begin
                if (bus.en_i) begin m_run = 1; m_stop = 0; m_pos = 0; end
            end else begin
                if (m_stop && !bus.en_i && m_pos == FRAME - 1) m_run = 0;
                m_stop = m_run && !bus.en_i;
                m_pos  = m_run ? (m_pos + 1) % FRAME : 0;
            end
        end
        chk("model", {dut_vec(), bus.underflow_o}, {exp_o, exp_uf});
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == p); i++) tick();
        chk($sformatf("reach_pos%0d", p), (m_run && m_pos == p) ? 1 : 0, 1);
    endtask

    initial begin
        int nfs, nreq, nvs, nhs, n;
        bit busy_drop;
        logic [9:0] e;
        tbl.push_back('{0, 0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{15, 0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16, 0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{17, 0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{18, 0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{20, 0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{21, 0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{22, 0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{23, 0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{30, 0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{31, 0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32, 0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{5, 2, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{31, 2, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{23, 3, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{31, 3, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 4, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{23, 4, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 5, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{19, 5, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{32, 6, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 7, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{23, 7, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32, 7, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0});

        bus.en_i = 1'b0; bus.px_valid_i = 1'b1; bus.clr_i = 1'b0;
        m_run = 0; m_stop = 0; m_pos = 0; exp_o = expect_out(0, 0); exp_uf = 1'b0;
        tick();
        tick();
        chk("reset_out", {dut_vec(), bus.underflow_o}, 12'h000);
        rst = 1'b0;
        tick();
        bus.en_i = 1'b1;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            cap[k] = dut_vec();
        end
        foreach (tbl[i]) begin
            e = {tbl[i].per == 2'd3, tbl[i].per, tbl[i].ctl, tbl[i].hs, tbl[i].vs, tbl[i].fs};
            chk($sformatf("tbl_h%0d_v%0d", tbl[i].h, tbl[i].v), cap[tbl[i].v * HT + tbl[i].h][10:1], e);
        end
        nfs = 0; nreq = 0; nvs = 0; nhs = 0;
        for (int k = 0; k < FRAME; k++) begin
            nfs += cap[k][1]; nreq += cap[k][10]; nvs += cap[k][2]; nhs += cap[k][3];
        end
        chk("fs_per_frame", nfs, 1);
        chk("req_per_frame", nreq, XR * YR);
        chk("vs_per_frame", nvs, VSW * HT);
        chk("hs_per_frame", nhs, HSW * VT);

        tick();
        bus.px_valid_i = 1'b0;
        tick();
        chk("uf_set", bus.underflow_o, 1);
        bus.px_valid_i = 1'b1;
        tick();
        chk("uf_hold", bus.underflow_o, 1);
        bus.clr_i = 1'b1;
        tick();
        chk("uf_clear", bus.underflow_o, 0);
        bus.px_valid_i = 1'b0;
        tick();
        chk("uf_set_beats_clr", bus.underflow_o, 1);
        tick();
        chk("uf_set_beats_clr2", bus.underflow_o, 1);
        bus.px_valid_i = 1'b1;
        tick();
        chk("uf_clear2", bus.underflow_o, 0);
        bus.clr_i = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 149) == 0) bus.en_i = !bus.en_i;
            bus.px_valid_i = $urandom_range(0, 14) != 0;
            bus.clr_i = $urandom_range(0, 19) == 0;
        end

        bus.en_i = 1'b1; bus.px_valid_i = 1'b1; bus.clr_i = 1'b1;
        goto_pos(100);
        bus.clr_i = 1'b0;
        bus.en_i = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (!bus.busy_o) break;
        end
        chk("stop_latency", n, FRAME + 1 - 100);
        chk("idle_out", dut_vec(), 11'h000);
        bus.en_i = 1'b1;
        tick();
        tick();
        chk("restart_fs", bus.frame_start_o, 1);
        goto_pos(200);
        bus.en_i = 1'b0;
        repeat (10) tick();
        bus.en_i = 1'b1;
        n = 0; busy_drop = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            busy_drop |= !bus.busy_o;
            if (bus.frame_start_o) break;
        end
        chk("back_to_back", n, FRAME - 210 + 1);
        chk("busy_kept", busy_drop, 0);
        goto_pos(250);
        bus.en_i = 1'b0;
        goto_pos(FRAME - 1);
        bus.en_i = 1'b1;
        tick();
        tick();
        chk("end_reenable_fs", bus.frame_start_o, 1);

        goto_pos(40);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {dut_vec(), bus.underflow_o}, 12'h000);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_restart_fs", bus.frame_start_o, 1);
        chk("rst_restart_period", bus.period_o, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Generates raster timing for the HDMI transmit path and schedules each pixel-clock cycle as control, video preamble, video guard band or video data period.
- Drives h/v sync, the per-lane period code and CTL bits used by the TMDS encoders.
- Issues pixel requests to the upstream video source and flags underflow.
- Runs in the pixel clock domain. Starts and stops only on frame boundaries.

Parameters:
- X_RES, 1920, active pixels per line
- Y_RES, 1080, active lines per frame
- H_FP, 88, horizontal front porch cycles
- H_SYNC, 44, horizontal sync width
- H_BP, 148, horizontal back porch; must be >= 10
- V_FP, 4, vertical front porch lines
- V_SYNC, 5, vertical sync lines
- V_BP, 36, vertical back porch lines
- HS_POL, 1, h_sync active level
- VS_POL, 1, v_sync active level

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  asynchronous active-high reset
- en_i  in  1  run request
- px_valid_i  in  1  upstream pixel available
- clr_i  in  1  clear sticky underflow flag
- px_req_o  out  1  pixel consumed this cycle (ready)
- period_o  out  2  0=CTRL 1=PREAMBLE 2=GUARD 3=VIDEO
- ctl_o  out  4  CTL3..CTL0 for red/green lanes
- h_sync_o  out  1  horizontal sync
- v_sync_o  out  1  vertical sync
- frame_start_o  out  1  pulse on first cycle of frame
- busy_o  out  1  state != IDLE
- underflow_o  out  1  sticky underflow flag

Behaviour:
- Reset and clocking: clk_i is the single clock; rst_i is asynchronous, active-high.
- Reset values:
  - counters 0, state IDLE;
  - px_req_o, frame_start_o, busy_o, underflow_o = 0;
  - period_o = 0, ctl_o = 0;
  - h_sync_o = !HS_POL, v_sync_o = !VS_POL.
- Totals: H_TOTAL = X_RES+H_FP+H_SYNC+H_BP; V_TOTAL = Y_RES+V_FP+V_SYNC+V_BP.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, running 0..V_TOTAL-1 and wrapping.
  - Counter widths are $clog2 of the totals.
- Raster layout: active region is h_cnt < X_RES and v_cnt < Y_RES.
- Sync decode:
  - h_sync is active for h_cnt in [X_RES+H_FP, X_RES+H_FP+H_SYNC-1].
  - v_sync is active for v_cnt in [Y_RES+V_FP, Y_RES+V_FP+V_SYNC-1], asserting/deasserting at h_cnt = 0.
- Period decode, in priority order:
  - VIDEO in the active region.
  - PREAMBLE for h_cnt in [H_TOTAL-10, H_TOTAL-3] on a line whose successor is active (v_cnt < Y_RES-1 or v_cnt = V_TOTAL-1).
  - GUARD for h_cnt in {H_TOTAL-2, H_TOTAL-1} under the same line condition.
  - CTRL otherwise.
- CTL bits: ctl_o = 4'b0001 during PREAMBLE, 4'b0000 otherwise.
- Pixel handshake:
  - px_req_o = 1 exactly when period_o = VIDEO.
  - Transfer is unconditional; the upstream must have px_valid_i high.
- Latency: all outputs are registered and reflect the counter value of the previous cycle (1-cycle latency). No combinational input-to-output paths.
- Underflow:
  - px_req_o=1 with px_valid_i=0 sets underflow_o on the next cycle; scheduling continues unaffected.
  - clr_i clears the flag; a set condition in the same cycle as clr_i wins (flag stays 1).
- frame_start_o: 1-cycle pulse, output-aligned with h_cnt=0, v_cnt=0 while RUN.
- FSM IDLE:
  - Counters held at 0; outputs at their reset values except underflow_o (held).
  - en_i=1 -> RUN; counting starts from h=0, v=0 on the next cycle.
- FSM RUN:
  - en_i=0 -> STOP_PEND.
- FSM STOP_PEND:
  - Keeps running normally.
  - en_i=1 -> RUN with no disturbance to the raster.
  - At h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 with en_i=0 -> IDLE.
  - Simultaneous frame end and en_i=1 -> RUN.
- busy_o = 1 in RUN and STOP_PEND.
- Reset mid-frame: all state returns to reset values immediately (asynchronously); no partial frame is resumed.

Test Plan:
- Bench parameters for all scenarios: X_RES=16, Y_RES=4, H_FP=2, H_SYNC=3, H_BP=12 (H_TOTAL=33), V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8).
- Reset, then en_i=1 -> frame_start_o pulses once; period_o=3 and px_req_o=1 for 16 cycles; h_sync_o active for output h=18..20.
- Line 0 blanking -> period_o=1 and ctl_o=0001 for h=23..30; period_o=2 at h=31..32; line 3 (last active) -> period_o stays 0 for the whole blanking.
- Line 7 (last blanking line) -> preamble/guard present; v_sync_o active on lines 5..6 only; 264 cycles per frame; px_req_o high exactly 64 cycles per frame.
- Drop px_valid_i for one active cycle -> underflow_o=1 next cycle and held; clr_i pulse -> 0; clr_i coincident with a new underflow -> stays 1.
- en_i=0 mid-frame -> frame completes, busy_o falls after the frame-end cycle, outputs idle; en_i re-raised during STOP_PEND -> next frame starts back-to-back.
- Assert rst_i mid-line -> outputs return to reset values without waiting for a clock edge; restart with en_i=1 begins at h=0, v=0.
